// File: rtl/pixel_colour_gen.sv
// Pixel colour stage for the VGA text path: font bit to R/G/B with loadable colours,
// inversion and a configurable output pipeline. Define CURSOR_BLINK_EN to build the blinking cursor.
module pixel_colour_gen #(
    parameter int CW           = 3,
    parameter int DELAY        = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          display_area,
    input  logic          serial_output,
    input  logic          frame_start,
    input  logic          cursor_here,
    input  logic          invert,
    input  logic          colour_we,
    input  logic [3*CW-1:0] fg_in,
    input  logic [3*CW-1:0] bg_in,
    output logic [CW-1:0] R,
    output logic [CW-1:0] G,
    output logic [CW-1:0] B,
    output logic          blank_out
);

    localparam int PW = 3 * CW;

    logic [PW-1:0] fg_reg;
    logic [PW-1:0] bg_reg;
    logic          cursor_term;
    logic          pix;
    logic [PW-1:0] colour_s1;

    logic [PW-1:0] colour_p [DELAY];
    logic          vld_p    [DELAY];

    function automatic logic [PW-1:0] select_colour(
        input logic          visible,
        input logic          bit_on,
        input logic [PW-1:0] fg,
        input logic [PW-1:0] bg
    );
        if (!visible)
            return '0;
        return bit_on ? fg : bg;
    endfunction

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            fg_reg <= '1;
            bg_reg <= '0;
        end else if (colour_we) begin
            fg_reg <= fg_in;
            bg_reg <= bg_in;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam logic [7:0] CNT_MAX = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt;
    logic       blink_phase;

    // Frame counter; frame_start is level-counted, so a held strobe counts every cycle.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == CNT_MAX) begin
                blink_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign cursor_term = cursor_here & blink_phase;
`else
    logic unused_cursor_inputs;
    assign unused_cursor_inputs = cursor_here ^ frame_start;
    assign cursor_term          = 1'b0;
`endif

    always_comb begin
        pix       = serial_output ^ invert ^ cursor_term;
        colour_s1 = select_colour(display_area, pix, fg_reg, bg_reg);
    end

    // Stage p0 samples the pixel; stages p1..p(DELAY-1) only delay colour and display_area together.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                colour_p[i] <= '0;
                vld_p[i]    <= 1'b0;
            end
        end else begin
            colour_p[0] <= colour_s1;
            vld_p[0]    <= display_area;
            for (int i = 1; i < DELAY; i++) begin
                colour_p[i] <= colour_p[i-1];
                vld_p[i]    <= vld_p[i-1];
            end
        end
    end

    assign R         = colour_p[DELAY-1][PW-1:2*CW];
    assign G         = colour_p[DELAY-1][2*CW-1:CW];
    assign B         = colour_p[DELAY-1][CW-1:0];
    assign blank_out = vld_p[DELAY-1];

endmodule

// File: tb/tb_pixel_colour_gen.sv
// Directed bench for pixel_colour_gen: one DELAY=1 and one DELAY=3 instance on shared inputs.
module tb_pixel_colour_gen;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_area = 1'b0;
    logic       serial_output = 1'b0;
    logic       frame_start = 1'b0;
    logic       cursor_here = 1'b0;
    logic       invert = 1'b0;
    logic       colour_we = 1'b0;
    logic [8:0] fg_in = 9'o000;
    logic [8:0] bg_in = 9'o000;

    logic [2:0] r1, g1, b1, r3, g3, b3;
    logic       blank1, blank3;

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    pixel_colour_gen #(.CW(3), .DELAY(1), .BLINK_FRAMES(2)) dut1 (
        .vga_clk(vga_clk), .reset(reset), .display_area(display_area),
        .serial_output(serial_output), .frame_start(frame_start),
        .cursor_here(cursor_here), .invert(invert), .colour_we(colour_we),
        .fg_in(fg_in), .bg_in(bg_in), .R(r1), .G(g1), .B(b1), .blank_out(blank1)
    );

    pixel_colour_gen #(.CW(3), .DELAY(3), .BLINK_FRAMES(2)) dut3 (
        .vga_clk(vga_clk), .reset(reset), .display_area(display_area),
        .serial_output(serial_output), .frame_start(frame_start),
        .cursor_here(cursor_here), .invert(invert), .colour_we(colour_we),
        .fg_in(fg_in), .bg_in(bg_in), .R(r3), .G(g3), .B(b3), .blank_out(blank3)
    );

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({r1, g1, b1, blank1} !== 10'b0) begin
            bad++; $display("FAIL reset_d1: got %b want 0", {r1, g1, b1, blank1});
        end
        total++;
        if ({r3, g3, b3, blank3} !== 10'b0) begin
            bad++; $display("FAIL reset_d3: got %b want 0", {r3, g3, b3, blank3});
        end
        @(negedge vga_clk);
        reset = 1'b0;
        display_area = 1'b1; serial_output = 1'b1;
        step();
        total++;
        if ({r1, g1, b1, blank1} !== {9'o777, 1'b1}) begin
            bad++; $display("FAIL white_fg: got %o/%b want 777/1", {r1, g1, b1}, blank1);
        end
        serial_output = 1'b0;
        step();
        total++;
        if ({r1, g1, b1, blank1} !== {9'o000, 1'b1}) begin
            bad++; $display("FAIL black_bg: got %o/%b want 000/1", {r1, g1, b1}, blank1);
        end
        display_area = 1'b0; serial_output = 1'b1;
        step();
        total++;
        if ({r1, g1, b1, blank1} !== {9'o000, 1'b0}) begin
            bad++; $display("FAIL outside_area: got %o/%b want 000/0", {r1, g1, b1}, blank1);
        end
    endtask

    task automatic test_colour_load();
        display_area = 1'b1; serial_output = 1'b1;
        colour_we = 1'b1; fg_in = 9'o520; bg_in = 9'o013;
        step();
        colour_we = 1'b0;
        total++;
        if ({r1, g1, b1} !== 9'o777) begin
            bad++; $display("FAIL load_same_edge: got %o want 777", {r1, g1, b1});
        end
        step();
        total++;
        if ({r1, g1, b1} !== 9'o520) begin
            bad++; $display("FAIL load_fg: got %o want 520", {r1, g1, b1});
        end
        serial_output = 1'b0;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL load_bg: got %o want 013", {r1, g1, b1});
        end
    endtask

    task automatic test_latency();
        display_area = 1'b0; serial_output = 1'b0;
        repeat (4) step();
        display_area = 1'b1; serial_output = 1'b1;
        step();
        display_area = 1'b0; serial_output = 1'b0;
        total++;
        if ({r3, g3, b3, blank3} !== 10'b0) begin
            bad++; $display("FAIL lat_n: got %o/%b want 000/0", {r3, g3, b3}, blank3);
        end
        step();
        total++;
        if ({r3, g3, b3, blank3} !== 10'b0) begin
            bad++; $display("FAIL lat_n1: got %o/%b want 000/0", {r3, g3, b3}, blank3);
        end
        step();
        total++;
        if ({r3, g3, b3, blank3} !== {9'o520, 1'b1}) begin
            bad++; $display("FAIL lat_n2: got %o/%b want 520/1", {r3, g3, b3}, blank3);
        end
        step();
        total++;
        if ({r3, g3, b3, blank3} !== 10'b0) begin
            bad++; $display("FAIL lat_n3: got %o/%b want 000/0", {r3, g3, b3}, blank3);
        end
    endtask

    task automatic test_invert();
        invert = 1'b1; display_area = 1'b1; serial_output = 1'b1;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL invert_on: got %o want 013", {r1, g1, b1});
        end
        serial_output = 1'b0;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o520) begin
            bad++; $display("FAIL invert_off: got %o want 520", {r1, g1, b1});
        end
        display_area = 1'b0;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o000) begin
            bad++; $display("FAIL invert_blank: got %o want 000", {r1, g1, b1});
        end
        invert = 1'b0;
    endtask

    task automatic test_blink();
        display_area = 1'b1; serial_output = 1'b0; cursor_here = 1'b1;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL blink_start: got %o want 013", {r1, g1, b1});
        end
        frame_start = 1'b1; step();
        frame_start = 1'b0; step();
        frame_start = 1'b1; step();
        frame_start = 1'b0;
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL blink_wrap_edge: got %o want 013", {r1, g1, b1});
        end
        step();
`ifdef CURSOR_BLINK_EN
        total++;
        if ({r1, g1, b1} !== 9'o520) begin
            bad++; $display("FAIL blink_high: got %o want 520", {r1, g1, b1});
        end
`else
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL cursor_ignored: got %o want 013", {r1, g1, b1});
        end
`endif
        // Held strobe: two cycles count as two frames.
        frame_start = 1'b1; step(); step();
        frame_start = 1'b0;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o013) begin
            bad++; $display("FAIL blink_low: got %o want 013", {r1, g1, b1});
        end
        cursor_here = 1'b0;
    endtask

    task automatic test_mid_reset();
        colour_we = 1'b1; fg_in = 9'o777; bg_in = 9'o456;
        step();
        colour_we = 1'b0; display_area = 1'b1; serial_output = 1'b1;
        repeat (3) step();
        total++;
        if ({r1, g1, b1} !== 9'o777) begin
            bad++; $display("FAIL pre_reset_white: got %o want 777", {r1, g1, b1});
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({r1, g1, b1, r3, g3, b3, blank1, blank3} !== 20'b0) begin
            bad++; $display("FAIL async_reset: got %o %o %b%b want 0", {r1, g1, b1}, {r3, g3, b3}, blank1, blank3);
        end
        @(negedge vga_clk);
        reset = 1'b0;
        serial_output = 1'b0;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o000) begin
            bad++; $display("FAIL bg_reverted: got %o want 000", {r1, g1, b1});
        end
        total++;
        if ({r3, g3, b3, blank3} !== 10'b0) begin
            bad++; $display("FAIL refill_d3: got %o/%b want 000/0", {r3, g3, b3}, blank3);
        end
        serial_output = 1'b1;
        step();
        total++;
        if ({r1, g1, b1} !== 9'o777) begin
            bad++; $display("FAIL fg_reverted: got %o want 777", {r1, g1, b1});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_colour_load();
        test_latency();
        test_invert();
        test_blink();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
